// File: rtl/pipe_control.sv
// pipe_control: MIPS ID-stage decode + hazard/redirect control carried through ID/EX, EX/MEM, MEM/WB; clk_i/rst_i, Op_i/RSaddr_i/RTaddr_i/Equal_i in, ID steering + staged control + StallCnt_o out
module pipe_control #(
    parameter int OP_W = 6,
    parameter int REG_W = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [OP_W-1:0]        Op_i,
    input  logic [REG_W-1:0]       RSaddr_i,
    input  logic [REG_W-1:0]       RTaddr_i,
    input  logic                   Equal_i,
    output logic                   Jump_o,
    output logic                   BranchTaken_o,
    output logic                   PCWrite_o,
    output logic                   IFIDWrite_o,
    output logic                   Flush_o,
    output logic                   RegDst_EX_o,
    output logic [1:0]             ALUOp_EX_o,
    output logic                   ALUSrc_EX_o,
    output logic                   MemRead_MEM_o,
    output logic                   MemWrite_MEM_o,
    output logic                   RegWrite_WB_o,
    output logic                   MemtoReg_WB_o,
    output logic [STALL_CNT_W-1:0] StallCnt_o
);
    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
    logic [9:0]       ctrl;
    logic [9:0]       id_ctrl;
    logic             hazard;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_reg_write;
    logic             ex_mem_to_reg;
    logic             mem_reg_write;
    logic             mem_mem_to_reg;
    logic [REG_W-1:0] ex_rt;
    always_comb begin
        ctrl = (Op_i == OP_R)    ? 10'b1_0_0_0_0_10_0_0_1 :
               (Op_i == OP_ADDI) ? 10'b0_0_0_0_0_00_0_1_1 :
               (Op_i == OP_LW)   ? 10'b0_0_0_1_1_00_0_1_1 :
               (Op_i == OP_SW)   ? 10'b0_0_0_0_0_00_1_1_0 :
               (Op_i == OP_BEQ)  ? 10'b0_0_1_0_0_01_0_0_0 :
               (Op_i == OP_J)    ? 10'b0_1_0_0_0_00_0_0_0 : '0;
        hazard = ex_mem_read && ex_rt != '0 && (ex_rt == RSaddr_i || ex_rt == RTaddr_i);
        id_ctrl = hazard ? '0 : ctrl;
        PCWrite_o = !hazard;
        IFIDWrite_o = !hazard;
        Jump_o = id_ctrl[8];
        BranchTaken_o = id_ctrl[7] && Equal_i;
        Flush_o = Jump_o || BranchTaken_o;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            RegDst_EX_o    <= 1'b0;
            ALUOp_EX_o     <= 2'b00;
            ALUSrc_EX_o    <= 1'b0;
            ex_mem_read    <= 1'b0;
            ex_mem_write   <= 1'b0;
            ex_reg_write   <= 1'b0;
            ex_mem_to_reg  <= 1'b0;
            ex_rt          <= '0;
            MemRead_MEM_o  <= 1'b0;
            MemWrite_MEM_o <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            RegWrite_WB_o  <= 1'b0;
            MemtoReg_WB_o  <= 1'b0;
            StallCnt_o     <= '0;
        end else begin
            RegDst_EX_o    <= id_ctrl[9];
            ALUOp_EX_o     <= id_ctrl[4:3];
            ALUSrc_EX_o    <= id_ctrl[1];
            ex_mem_read    <= id_ctrl[6];
            ex_mem_write   <= id_ctrl[2];
            ex_reg_write   <= id_ctrl[0];
            ex_mem_to_reg  <= id_ctrl[5];
            ex_rt          <= hazard ? '0 : RTaddr_i;
            MemRead_MEM_o  <= ex_mem_read;
            MemWrite_MEM_o <= ex_mem_write;
            mem_reg_write  <= ex_reg_write;
            mem_mem_to_reg <= ex_mem_to_reg;
            RegWrite_WB_o  <= mem_reg_write;
            MemtoReg_WB_o  <= mem_mem_to_reg;
            StallCnt_o     <= (hazard && !(&StallCnt_o)) ? StallCnt_o + STALL_CNT_W'(1) : StallCnt_o;
        end
    end
endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: table-driven and randomized checks of pipe_control against a cycle model
module tb_pipe_control;
    localparam int SW = 2;
    localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, LW = 6'b100011;
    localparam logic [5:0] SWO = 6'b101011, BEQ = 6'b000100, J = 6'b000010, ILL = 6'b111111;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic [5:0] Op_i = '0;
    logic [4:0] RSaddr_i = '0, RTaddr_i = '0;
    logic Equal_i = 1'b0;
    logic Jump_o, BranchTaken_o, PCWrite_o, IFIDWrite_o, Flush_o;
    logic RegDst_EX_o, ALUSrc_EX_o, MemRead_MEM_o, MemWrite_MEM_o, RegWrite_WB_o, MemtoReg_WB_o;
    logic [1:0] ALUOp_EX_o;
    logic [SW-1:0] StallCnt_o;
    int checks = 0, errors = 0;
    logic [9:0] hist [3];
    logic [4:0] m_rt;
    int m_cnt;
    logic [14:0] act;

    pipe_control #(.OP_W(6), .REG_W(5), .STALL_CNT_W(SW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
        .Equal_i(Equal_i), .Jump_o(Jump_o), .BranchTaken_o(BranchTaken_o), .PCWrite_o(PCWrite_o),
        .IFIDWrite_o(IFIDWrite_o), .Flush_o(Flush_o), .RegDst_EX_o(RegDst_EX_o),
        .ALUOp_EX_o(ALUOp_EX_o), .ALUSrc_EX_o(ALUSrc_EX_o), .MemRead_MEM_o(MemRead_MEM_o),
        .MemWrite_MEM_o(MemWrite_MEM_o), .RegWrite_WB_o(RegWrite_WB_o),
        .MemtoReg_WB_o(MemtoReg_WB_o), .StallCnt_o(StallCnt_o)
    );

    always #5 clk_i = ~clk_i;

    assign act = {PCWrite_o, IFIDWrite_o, Flush_o, Jump_o, BranchTaken_o, RegDst_EX_o, ALUOp_EX_o,
                  ALUSrc_EX_o, MemRead_MEM_o, MemWrite_MEM_o, RegWrite_WB_o, MemtoReg_WB_o, StallCnt_o};

    // {RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}
    function automatic logic [9:0] dec(input logic [5:0] op);
        case (op)
            R:       return 10'b1_0_0_0_0_10_0_0_1;
            ADDI:    return 10'b0_0_0_0_0_00_0_1_1;
            LW:      return 10'b0_0_0_1_1_00_0_1_1;
            SWO:     return 10'b0_0_0_0_0_00_1_1_0;
            BEQ:     return 10'b0_0_1_0_0_01_0_0_0;
            J:       return 10'b0_1_0_0_0_00_0_0_0;
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic m_haz(input logic [4:0] rs, input logic [4:0] rt);
        return hist[0][6] && m_rt != 0 && (m_rt == rs || m_rt == rt);
    endfunction

    function automatic logic [14:0] m_out(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic eq);
        logic h, jm, bt;
        h = m_haz(rs, rt);
        jm = !h && dec(op)[8];
        bt = !h && dec(op)[7] && eq;
        return {!h, !h, jm || bt, jm, bt, hist[0][9], hist[0][4:3], hist[0][1],
                hist[1][6], hist[1][2], hist[2][0], hist[2][5], SW'(m_cnt)};
    endfunction

    task automatic check(input string name, input logic [14:0] a, input logic [14:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, a, e);
        end
    endtask

    task automatic step(input logic rst, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic eq, input logic chk,
                        input logic tchk, input logic [14:0] texp);
        logic h;
        rst_i = rst; Op_i = op; RSaddr_i = rs; RTaddr_i = rt; Equal_i = eq;
        #3;
        if (chk) check("model", act, m_out(op, rs, rt, eq));
        if (tchk) check("table", act, texp);
        h = m_haz(rs, rt);
        @(posedge clk_i);
        if (rst) begin
            hist[0] = '0; hist[1] = '0; hist[2] = '0; m_rt = '0; m_cnt = 0;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = h ? 10'b0 : dec(op);
            m_rt = h ? 5'd0 : rt;
            if (h && m_cnt < (1 << SW) - 1) m_cnt++;
        end
        #1;
    endtask

    typedef struct {
        logic rst; logic [5:0] op; logic [4:0] rs; logic [4:0] rt; logic eq; logic chk;
        logic pc; logic fl; logic jm; logic bt; logic [3:0] ex; logic [1:0] mm; logic [1:0] wb; logic [1:0] cnt;
    } vec_t;

    vec_t tbl [19];
    logic [5:0] ops [7];

    initial begin
        ops = '{R, ADDI, LW, SWO, BEQ, J, ILL};
        // ex = {RegDst, ALUOp, ALUSrc}, mm = {MemRead, MemWrite}, wb = {RegWrite, MemtoReg}
        tbl[0]  = '{1, R,    0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0};
        tbl[1]  = '{0, LW,   1, 5, 0, 1,  1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0};
        tbl[2]  = '{0, R,    5, 2, 0, 1,  0, 0, 0, 0, 4'b0001, 2'b00, 2'b00, 0};
        tbl[3]  = '{0, R,    5, 2, 0, 1,  1, 0, 0, 0, 4'b0000, 2'b10, 2'b00, 1};
        tbl[4]  = '{0, ADDI, 0, 0, 0, 1,  1, 0, 0, 0, 4'b1100, 2'b00, 2'b11, 1};
        tbl[5]  = '{0, LW,   2, 0, 0, 1,  1, 0, 0, 0, 4'b0001, 2'b00, 2'b00, 1};
        tbl[6]  = '{0, R,    0, 0, 0, 1,  1, 0, 0, 0, 4'b0001, 2'b00, 2'b10, 1};
        tbl[7]  = '{0, BEQ,  1, 2, 1, 1,  1, 1, 0, 1, 4'b1100, 2'b10, 2'b10, 1};
        tbl[8]  = '{0, BEQ,  1, 2, 0, 1,  1, 0, 0, 0, 4'b0010, 2'b00, 2'b11, 1};
        tbl[9]  = '{0, J,    0, 0, 0, 1,  1, 1, 1, 0, 4'b0010, 2'b00, 2'b10, 1};
        tbl[10] = '{0, LW,   0, 3, 0, 1,  1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 1};
        tbl[11] = '{0, BEQ,  3, 4, 1, 1,  0, 0, 0, 0, 4'b0001, 2'b00, 2'b00, 1};
        tbl[12] = '{0, BEQ,  3, 4, 1, 1,  1, 1, 0, 1, 4'b0000, 2'b10, 2'b00, 2};
        tbl[13] = '{0, ILL,  0, 0, 0, 1,  1, 0, 0, 0, 4'b0010, 2'b00, 2'b11, 2};
        tbl[14] = '{0, LW,   0, 7, 0, 1,  1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 2};
        tbl[15] = '{0, SWO,  7, 1, 0, 1,  0, 0, 0, 0, 4'b0001, 2'b00, 2'b00, 2};
        tbl[16] = '{0, LW,   0, 6, 0, 1,  1, 0, 0, 0, 4'b0000, 2'b10, 2'b00, 3};
        tbl[17] = '{1, R,    6, 0, 0, 1,  0, 0, 0, 0, 4'b0001, 2'b00, 2'b11, 3};
        tbl[18] = '{0, R,    0, 0, 0, 1,  1, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0};
        step(1, R, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            step($urandom_range(0, 49) == 0, op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1, 0, '0);
        end
        for (int i = 0; i < 19; i++)
            step(tbl[i].rst, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].eq, 1, tbl[i].chk,
                 {tbl[i].pc, tbl[i].pc, tbl[i].fl, tbl[i].jm, tbl[i].bt, tbl[i].ex, tbl[i].mm,
                  tbl[i].wb, tbl[i].cnt});
        step(1, R, 0, 0, 0, 1, 0, '0);
        // a repeated lw $1 using $1 stalls every other cycle, driving the counter past its top
        for (int i = 0; i < 2 * ((1 << SW) + 2); i++) step(0, LW, 1, 1, 0, 1, 0, '0);
        checks++;
        if (StallCnt_o !== 2'd3) begin
            errors++;
            $display("FAIL stall_saturate: got %0d want 3", StallCnt_o);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Pipelined successor to the single-cycle main control decoder for the 5-stage MIPS core.
- Decodes the ID-stage opcode into the standard control bundle.
- Carries that bundle through ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards (stall plus bubble) and resolves branch/jump redirects in ID (IF/ID flush).

Parameters:
OP_W, 6, opcode width
REG_W, 5, register-address width
STALL_CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
Op_i  in  OP_W  opcode of instruction in ID
RSaddr_i  in  REG_W  rs field of ID instruction
RTaddr_i  in  REG_W  rt field of ID instruction
Equal_i  in  1  ID-stage register compare result (rs==rt)
Jump_o  out  1  combinational, ID: select jump target
BranchTaken_o  out  1  combinational, ID: select branch target
PCWrite_o  out  1  combinational, 0 = hold PC
IFIDWrite_o  out  1  combinational, 0 = hold IF/ID
Flush_o  out  1  combinational, 1 = zero IF/ID next edge
RegDst_EX_o  out  1  registered, EX stage
ALUOp_EX_o  out  2  registered, EX stage
ALUSrc_EX_o  out  1  registered, EX stage
MemRead_MEM_o  out  1  registered, MEM stage
MemWrite_MEM_o  out  1  registered, MEM stage
RegWrite_WB_o  out  1  registered, WB stage
MemtoReg_WB_o  out  1  registered, WB stage
StallCnt_o  out  STALL_CNT_W  registered, saturating count of stall cycles

Behaviour:
- Decode (combinational) produces {RegDst, Jump, Branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite}:
  - 000000 (R-type) = 1,0,0,0,0,10,0,0,1
  - 001000 (addi) = 0,0,0,0,0,00,0,1,1
  - 100011 (lw) = 0,0,0,1,1,00,0,1,1
  - 101011 (sw) = 0,0,0,0,0,00,1,1,0
  - 000100 (beq) = 0,0,1,0,0,01,0,0,0
  - 000010 (j) = 0,1,0,0,0,00,0,0,0
  - any other opcode: all zero (NOP). No latching of the previous value.
  - Opcodes are zero-extended/compared at width OP_W.
- Internal ID/EX state: EX control, MEM control, WB control, and EX_rt (REG_W).
- Internal EX/MEM state: MEM and WB control.
- MEM/WB state: WB control.
- Every pipeline register advances every cycle; this block has no external stall input.
- Load-use hazard (combinational): Hazard = EX.MemRead && EX_rt!=0 && (EX_rt==RSaddr_i || EX_rt==RTaddr_i).
  - Checks both fields regardless of opcode.
- While Hazard=1:
  - PCWrite_o=0, IFIDWrite_o=0.
  - ID/EX loads all-zero control (bubble); EX_rt is loaded as 0.
  - Jump_o, BranchTaken_o and Flush_o are forced to 0; the redirect is re-evaluated when the instruction is re-decoded next cycle.
  - StallCnt_o increments, saturating at all-ones.
- While Hazard=0:
  - PCWrite_o=1, IFIDWrite_o=1.
  - ID/EX loads the decoded bundle and EX_rt=RTaddr_i.
  - BranchTaken_o = Branch && Equal_i; Jump_o = Jump.
  - Flush_o = BranchTaken_o || Jump_o.
- Latency: decode to EX outputs 1 cycle; to MEM outputs 2 cycles; to WB outputs 3 cycles.
- A flushed IF/ID holds opcode 000000 with rd=0. It decodes as an R-type writing $0, which is harmless; no special handling.
- Reset (rst_i=1 at a clk_i edge):
  - All pipeline control registers, EX_rt and StallCnt_o are cleared to 0.
  - All registered outputs read 0 the cycle after.
  - Reset overrides a concurrent hazard or redirect.
  - Mid-stream reset discards in-flight control.
  - Combinational outputs after reset: Hazard=0 and PCWrite_o=IFIDWrite_o=1.

Test Plan:
- Reset: rst_i=1 one edge with random prior state -> all registered outputs 0, StallCnt_o=0, PCWrite_o=1, Flush_o=0.
- Decode/latency: Op_i=100011 at cycle 0, then 000000 -> cycle 1 ALUSrc_EX_o=1, ALUOp_EX_o=00; cycle 2 MemRead_MEM_o=1; cycle 3 RegWrite_WB_o=1, MemtoReg_WB_o=1. Cycle 2 EX shows RegDst_EX_o=1, ALUOp_EX_o=10.
- Load-use: lw with rt=5, next ID has rs=5 -> one cycle PCWrite_o=0, IFIDWrite_o=0, next EX bundle all 0, StallCnt_o=1. Same with rt=0 -> no stall.
- Branch: beq with Equal_i=1 -> BranchTaken_o=1, Flush_o=1. With Equal_i=0 -> both 0. j -> Jump_o=1, Flush_o=1.
- Stall beats redirect: lw rt=3 in EX, beq rs=3 Equal_i=1 in ID -> Flush_o=0 and BranchTaken_o=0 that cycle; next cycle Flush_o=1.
- Illegal opcode 111111 -> all-zero bundle propagates. Force 2^STALL_CNT_W+2 stall cycles (small STALL_CNT_W=2) -> StallCnt_o saturates at 3.
